// File: rtl/card_pkg.sv
// Shared types, constants and helpers for the card dealer and its hand scorers.
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_KING  = 4'd13;

    localparam logic [2:0] SLOT_P1 = 3'd0;
    localparam logic [2:0] SLOT_P2 = 3'd1;
    localparam logic [2:0] SLOT_P3 = 3'd2;
    localparam logic [2:0] SLOT_B1 = 3'd4;
    localparam logic [2:0] SLOT_B2 = 3'd5;
    localparam logic [2:0] SLOT_B3 = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    // Baccarat value: pip cards count face value, tens and court cards count zero.
    function automatic logic [3:0] card_value(input card_t c);
        logic [3:0] v;
        if (c <= 4'd9) begin
            v = c;
        end else begin
            v = 4'd0;
        end
        return v;
    endfunction

    function automatic logic [3:0] mod10(input logic [4:0] s);
        logic [4:0] r;
        if (s >= 5'd20) begin
            r = s - 5'd20;
        end else if (s >= 5'd10) begin
            r = s - 5'd10;
        end else begin
            r = s;
        end
        return r[3:0];
    endfunction

endpackage

// File: rtl/card_dealer_hand_score.sv
// hand_score: registered baccarat score (0..9) of one three-card hand.
module hand_score
    import card_pkg::*;
(
    input  logic       clock,
    input  logic       resetb,
    input  logic       clear_i,
    input  card_t      card1_i,
    input  card_t      card2_i,
    input  card_t      card3_i,
    output logic [3:0] score_o
);

    logic [4:0] sum_s;
    logic [3:0] score_d;
    logic [3:0] score_q;

    // Sum of three values is at most 27, so 5 bits suffice.
    always_comb begin
        sum_s   = {1'b0, card_value(card1_i)} + {1'b0, card_value(card2_i)}
                + {1'b0, card_value(card3_i)};
        score_d = mod10(sum_s);
    end

    // Score register; clear zeroes it on the same edge the slots are wiped.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            score_q <= 4'd0;
        end else if (clear_i) begin
            score_q <= 4'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score_o = score_q;

endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals rank-source cards into six hand slots via a req/ack handshake.
// Build option CARD_DEALER_LFSR_EN swaps the sequential rank counter for an 8-bit LFSR.
module card_dealer
    import card_pkg::*;
#(
    parameter card_t RANK_MIN = CARD_ACE,
    parameter card_t RANK_MAX = CARD_KING
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       deal_req,
    input  logic [2:0] deal_slot,
    input  logic       clear,
    output logic       deal_ack,
    output logic       deal_err,
    output card_t      pcard1,
    output card_t      pcard2,
    output card_t      pcard3,
    output card_t      bcard1,
    output card_t      bcard2,
    output card_t      bcard3,
    output logic [3:0] pscore,
    output logic [3:0] bscore
);

    state_t           st_q, st_d;
    logic [5:0][3:0]  slot_q, slot_d;
    logic [2:0]       sel_q, sel_d;
    card_t            cap_q, cap_d;
    logic             err_q, err_d;
    card_t            rank_s;
    logic [2:0]       idx_s;
    logic             valid_s;
    logic             slot_ok_s;

`ifdef CARD_DEALER_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] lmod_s;

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR; rank folds it into 1..13.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        lmod_s = lfsr_q % 8'd13;
        rank_s = lmod_s[3:0] + 4'd1;
    end

    // LFSR register, seeded to 1 so it never locks at zero.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    card_t rank_q, rank_d;

    // Wrapping rank counter, RANK_MIN..RANK_MAX.
    always_comb begin
        if (rank_q >= RANK_MAX) begin
            rank_d = RANK_MIN;
        end else begin
            rank_d = rank_q + 4'd1;
        end
        rank_s = rank_q;
    end

    // Rank counter register, untouched by clear and dealing.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            rank_q <= RANK_MIN;
        end else begin
            rank_q <= rank_d;
        end
    end
`endif

    // Map slot select 0..2 / 4..6 onto slot storage 0..5; codes 3 and 7 are invalid.
    always_comb begin
        valid_s = (sel_q[1:0] != 2'b11);
        if (!valid_s) begin
            idx_s = 3'd0;
        end else if (sel_q[2]) begin
            idx_s = {1'b0, sel_q[1:0]} + 3'd3;
        end else begin
            idx_s = {1'b0, sel_q[1:0]};
        end
        slot_ok_s = valid_s && (slot_q[idx_s] == CARD_EMPTY);
    end

    // FSM next state.
    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE: begin
                if (deal_req && !clear) begin
                    st_d = ST_LOAD;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_LOAD: st_d = ST_ACK;
            ST_ACK:  st_d = ST_WAIT;
            ST_WAIT: begin
                if (!deal_req) begin
                    st_d = ST_IDLE;
                end else begin
                    st_d = ST_WAIT;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // Datapath next state: capture, slot write, error flag and clear.
    always_comb begin
        sel_d  = sel_q;
        cap_d  = cap_q;
        err_d  = err_q;
        slot_d = slot_q;
        if (st_q == ST_IDLE && deal_req && !clear) begin
            sel_d = deal_slot;
            cap_d = rank_s;
        end else begin
            sel_d = sel_q;
            cap_d = cap_q;
        end
        if (st_q == ST_LOAD) begin
            err_d = !clear && !slot_ok_s;
        end else begin
            err_d = err_q;
        end
        if (clear) begin
            slot_d = '0;
        end else if (st_q == ST_LOAD && slot_ok_s) begin
            slot_d[idx_s] = cap_q;
        end else begin
            slot_d = slot_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            st_q   <= ST_IDLE;
            sel_q  <= 3'd0;
            cap_q  <= CARD_EMPTY;
            err_q  <= 1'b0;
            slot_q <= '0;
        end else begin
            st_q   <= st_d;
            sel_q  <= sel_d;
            cap_q  <= cap_d;
            err_q  <= err_d;
            slot_q <= slot_d;
        end
    end

    // FSM outputs.
    always_comb begin
        deal_ack = 1'b0;
        deal_err = 1'b0;
        if (st_q == ST_ACK) begin
            deal_ack = 1'b1;
            deal_err = err_q;
        end else begin
            deal_ack = 1'b0;
            deal_err = 1'b0;
        end
    end

    assign pcard1 = slot_q[0];
    assign pcard2 = slot_q[1];
    assign pcard3 = slot_q[2];
    assign bcard1 = slot_q[3];
    assign bcard2 = slot_q[4];
    assign bcard3 = slot_q[5];

    hand_score u_pscore (
        .clock   (clock),
        .resetb  (resetb),
        .clear_i (clear),
        .card1_i (slot_q[0]),
        .card2_i (slot_q[1]),
        .card3_i (slot_q[2]),
        .score_o (pscore)
    );

    hand_score u_bscore (
        .clock   (clock),
        .resetb  (resetb),
        .clear_i (clear),
        .card1_i (slot_q[3]),
        .card2_i (slot_q[4]),
        .card3_i (slot_q[5]),
        .score_o (bscore)
    );

endmodule

// File: tb/tb_card_dealer.sv
// Directed, table-driven bench for card_dealer (default sequential-counter build).
module tb_card_dealer;
    import card_pkg::*;

    logic       clock;
    logic       resetb;
    logic       deal_req;
    logic [2:0] deal_slot;
    logic       clear;
    logic       deal_ack;
    logic       deal_err;
    logic [3:0] pcard1, pcard2, pcard3, bcard1, bcard2, bcard3;
    logic [3:0] pscore, bscore;

    int checks   = 0;
    int failures = 0;

    card_dealer dut (
        .clock     (clock),
        .resetb    (resetb),
        .deal_req  (deal_req),
        .deal_slot (deal_slot),
        .clear     (clear),
        .deal_ack  (deal_ack),
        .deal_err  (deal_err),
        .pcard1    (pcard1),
        .pcard2    (pcard2),
        .pcard3    (pcard3),
        .bcard1    (bcard1),
        .bcard2    (bcard2),
        .bcard3    (bcard3),
        .pscore    (pscore),
        .bscore    (bscore)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit         clr;
        logic [2:0] slot;
        logic [3:0] rank;
        bit         err;
        logic [3:0] p1, p2, p3, b1, b2, b3, ps, bs;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_rank(input logic [3:0] target);
        int n = 0;
        while (dut.rank_s != target && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("rank_wait", int'(dut.rank_s), int'(target));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clr_slots", int'({pcard1, pcard2, pcard3, bcard1, bcard2, bcard3}), 0);
        check("clr_scores", int'({pscore, bscore}), 0);
    endtask

    initial begin
        int acks;
        logic [3:0] exp_r;

        vecs[0]  = '{1'b0, 3'd0, 4'd7,  1'b0, 4'd7, 4'd0, 4'd0,  4'd0, 4'd0, 4'd0,  4'd7, 4'd0};
        vecs[1]  = '{1'b1, 3'd0, 4'd9,  1'b0, 4'd9, 4'd0, 4'd0,  4'd0, 4'd0, 4'd0,  4'd9, 4'd0};
        vecs[2]  = '{1'b0, 3'd1, 4'd5,  1'b0, 4'd9, 4'd5, 4'd0,  4'd0, 4'd0, 4'd0,  4'd4, 4'd0};
        vecs[3]  = '{1'b0, 3'd2, 4'd13, 1'b0, 4'd9, 4'd5, 4'd13, 4'd0, 4'd0, 4'd0,  4'd4, 4'd0};
        vecs[4]  = '{1'b0, 3'd1, 4'd3,  1'b1, 4'd9, 4'd5, 4'd13, 4'd0, 4'd0, 4'd0,  4'd4, 4'd0};
        vecs[5]  = '{1'b0, 3'd3, 4'd2,  1'b1, 4'd9, 4'd5, 4'd13, 4'd0, 4'd0, 4'd0,  4'd4, 4'd0};
        vecs[6]  = '{1'b0, 3'd4, 4'd8,  1'b0, 4'd9, 4'd5, 4'd13, 4'd8, 4'd0, 4'd0,  4'd4, 4'd8};
        vecs[7]  = '{1'b0, 3'd5, 4'd6,  1'b0, 4'd9, 4'd5, 4'd13, 4'd8, 4'd6, 4'd0,  4'd4, 4'd4};
        vecs[8]  = '{1'b0, 3'd6, 4'd10, 1'b0, 4'd9, 4'd5, 4'd13, 4'd8, 4'd6, 4'd10, 4'd4, 4'd4};
        vecs[9]  = '{1'b0, 3'd7, 4'd1,  1'b1, 4'd9, 4'd5, 4'd13, 4'd8, 4'd6, 4'd10, 4'd4, 4'd4};
        vecs[10] = '{1'b0, 3'd4, 4'd1,  1'b1, 4'd9, 4'd5, 4'd13, 4'd8, 4'd6, 4'd10, 4'd4, 4'd4};

        resetb    = 1'b0;
        deal_req  = 1'b0;
        deal_slot = 3'd0;
        clear     = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ack", int'(deal_ack), 0);
        check("rst_err", int'(deal_err), 0);
        check("rst_slots", int'({pcard1, pcard2, pcard3, bcard1, bcard2, bcard3}), 0);
        check("rst_scores", int'({pscore, bscore}), 0);
        check("rst_state", int'(dut.st_q), int'(ST_IDLE));
        resetb = 1'b1;

        // Counter after reset: 1..5, then wrap 13 -> 1, never 0.
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("cnt_%0d", i), int'(dut.rank_s), i);
            @(negedge clock);
        end
        exp_r = 4'd6;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("wrap_%0d", i), int'(dut.rank_s), int'(exp_r));
            if (dut.rank_s == 4'd0) check("cnt_zero", 1, 0);
            exp_r = (exp_r == 4'd13) ? 4'd1 : exp_r + 4'd1;
            @(negedge clock);
        end

        // Table of single deals; slots/scores are cumulative.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].clr) do_clear();
            wait_rank(vecs[i].rank);
            deal_req  = 1'b1;
            deal_slot = vecs[i].slot;
            @(negedge clock);
            check($sformatf("v%0d_ack_load", i), int'(deal_ack), 0);
            @(negedge clock);
            check($sformatf("v%0d_ack", i), int'(deal_ack), 1);
            check($sformatf("v%0d_err", i), int'(deal_err), int'(vecs[i].err));
            check($sformatf("v%0d_p1", i), int'(pcard1), int'(vecs[i].p1));
            check($sformatf("v%0d_p2", i), int'(pcard2), int'(vecs[i].p2));
            check($sformatf("v%0d_p3", i), int'(pcard3), int'(vecs[i].p3));
            check($sformatf("v%0d_b1", i), int'(bcard1), int'(vecs[i].b1));
            check($sformatf("v%0d_b2", i), int'(bcard2), int'(vecs[i].b2));
            check($sformatf("v%0d_b3", i), int'(bcard3), int'(vecs[i].b3));
            deal_req = 1'b0;
            @(negedge clock);
            check($sformatf("v%0d_ack_off", i), int'(deal_ack), 0);
            check($sformatf("v%0d_ps", i), int'(pscore), int'(vecs[i].ps));
            check($sformatf("v%0d_bs", i), int'(bscore), int'(vecs[i].bs));
            @(negedge clock);
        end

        // deal_req held for 10 cycles yields exactly one ack.
        do_clear();
        deal_req  = 1'b1;
        deal_slot = SLOT_P1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (deal_ack) acks++;
        end
        deal_req = 1'b0;
        check("held_acks", acks, 1);
        check("held_p1_nonzero", int'(pcard1 != 4'd0), 1);
        repeat (2) @(negedge clock);

        // clear during LOAD suppresses the write but still acks without error.
        do_clear();
        deal_req  = 1'b1;
        deal_slot = SLOT_P1;
        @(negedge clock);
        check("cl_state_load", int'(dut.st_q), int'(ST_LOAD));
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("cl_ack", int'(deal_ack), 1);
        check("cl_err", int'(deal_err), 0);
        check("cl_p1", int'(pcard1), 0);
        deal_req = 1'b0;
        @(negedge clock);
        check("cl_ps", int'(pscore), 0);
        @(negedge clock);

        // clear together with a request in IDLE holds the request off.
        clear     = 1'b1;
        deal_req  = 1'b1;
        deal_slot = SLOT_B1;
        @(negedge clock);
        check("clidle_state", int'(dut.st_q), int'(ST_IDLE));
        clear = 1'b0;
        @(negedge clock);
        check("clidle_load", int'(dut.st_q), int'(ST_LOAD));
        @(negedge clock);
        check("clidle_ack", int'(deal_ack), 1);
        check("clidle_b1", int'(bcard1 != 4'd0), 1);

        // Reset during WAIT returns to IDLE with no ack, slots wiped.
        deal_slot = SLOT_P2;
        @(negedge clock);
        check("rw_wait", int'(dut.st_q), int'(ST_WAIT));
        deal_req = 1'b0;
        repeat (2) @(negedge clock);
        deal_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rw_ack", int'(deal_ack), 1);
        @(negedge clock);
        check("rw_wait2", int'(dut.st_q), int'(ST_WAIT));
        resetb = 1'b0;
        @(negedge clock);
        check("rw_state", int'(dut.st_q), int'(ST_IDLE));
        check("rw_ackoff", int'(deal_ack), 0);
        check("rw_p2", int'(pcard2), 0);
        check("rw_b1", int'(bcard1), 0);
        check("rw_rank", int'(dut.rank_s), 1);
        deal_req = 1'b0;
        resetb   = 1'b1;
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Upstream stage of the per-card 7-segment decoders. Deals 4-bit card codes into six hand slots: player cards 1–3 and banker cards 1–3.
- Each slot output drives one decoder directly. Code 0 means the slot is empty and the decoder shows a blank digit.
- A free-running rank counter supplies the cards. A four-phase req/ack handshake from the game controller selects which slot to fill.
- The block also keeps a registered baccarat score (0–9) for each hand.

Parameters:
- RANK_MIN, 1, lowest card code produced (Ace).
- RANK_MAX, 13, highest card code produced (King); the counter wraps from RANK_MAX to RANK_MIN.

Ports:
- clock  in  1  single design clock; all state updates on its rising edge.
- resetb  in  1  synchronous, active-low reset.
- deal_req  in  1  four-phase request; held high until deal_ack is seen.
- deal_slot  in  3  slot select, sampled with deal_req: 0/1/2 = player card 1/2/3; 4/5/6 = banker card 1/2/3; 3 and 7 are invalid.
- clear  in  1  synchronous clear of all slots and scores (new round).
- deal_ack  out  1  one-cycle acknowledge pulse.
- deal_err  out  1  high with deal_ack when the selected slot was invalid or already occupied.
- pcard1, pcard2, pcard3  out  4 each  player slot codes (0 = empty).
- bcard1, bcard2, bcard3  out  4 each  banker slot codes (0 = empty).
- pscore  out  4  player hand score, 0..9.
- bscore  out  4  banker hand score, 0..9.

Behaviour:
- Reset (resetb low at a clock edge):
  - all slots, pscore, bscore, deal_ack and deal_err go to 0;
  - rank counter goes to RANK_MIN;
  - FSM goes to IDLE.
  - Reset overrides any in-flight handshake.
- Rank counter:
  - increments every cycle when not in reset, RANK_MIN..RANK_MAX, wrapping to RANK_MIN;
  - never produces 0, 14 or 15;
  - is not affected by clear or by dealing.
- FSM states: IDLE, LOAD, ACK, WAIT.
  - IDLE → LOAD when deal_req=1 and clear=0. deal_slot and the current counter value are captured at that edge.
  - LOAD (1 cycle): if the slot is valid and holds 0, the captured rank is written to it; otherwise the error flag is set internally. Then → ACK.
  - ACK (1 cycle): deal_ack=1, and deal_err=1 if the error flag is set. Then → WAIT.
  - WAIT: stays until deal_req=0, then → IDLE. A deal_req still high in WAIT is not a new request.
- Latency: request edge to ack is 2 cycles; the slot output updates at the start of the ACK cycle.
- Scores:
  - card value is the code for 1..9 and 0 for codes 0 and 10..13;
  - pscore = (v(pcard1)+v(pcard2)+v(pcard3)) mod 10, held in a register; same for bscore with the banker slots;
  - the 5-bit intermediate sum is at most 27; the score updates one cycle after the slot write, i.e. it is valid in the cycle after deal_ack.
- clear:
  - takes effect the next edge: slots and scores go to 0;
  - in LOAD, the pending write is suppressed, but the FSM still proceeds to ACK with deal_err=0;
  - in IDLE, clear together with deal_req means clear wins and the request is held off until clear drops.
- Occupied slots are never overwritten; a second deal to the same slot returns deal_err.

Optional Feature:
- Macro: CARD_DEALER_LFSR_EN.
- Defined:
  - the rank source is an 8-bit maximal-length LFSR, taps x^8+x^6+x^5+x^4+1, seeded to 8'h01 on reset and stepped every cycle;
  - the dealt rank is (lfsr mod 13)+1.
- Undefined: the sequential rank counter described above is used. The handshake, scores and the error/clear rules are identical in both builds.

Decomposition:
- Package card_pkg holds:
  - typedef card_t (logic [3:0]);
  - constants CARD_EMPTY=0, CARD_ACE=1, CARD_KING=13;
  - slot encodings SLOT_P1..SLOT_B3;
  - the FSM state enum;
  - function card_value(card_t) returning 0..9.
- One natural sub-module, hand_score: three card_t inputs, clock and resetb in; registered 4-bit score out. Instantiated once per hand.

Test Plan:
- Reset then idle 5 cycles → all slots 0, scores 0; an internal counter probe shows 1,2,3,4,5.
- Counter wrap → after 13 cycles the probe shows 13 followed by 1; 0 is never produced.
- deal_req with slot 0 raised when the counter is 7 → deal_ack 2 cycles later, deal_err=0, pcard1=7; pscore=7 one cycle later.
- Deal player 9, 5 and King into slots 0–2 → pscore=4 (14 mod 10, King=0). Redeal slot 1 → deal_err=1 and pcard2 stays 5.
- deal_slot=3 → deal_err=1 and no slot changes. deal_req held high 10 cycles → exactly one deal_ack.
- clear asserted in LOAD → slot stays 0, deal_ack with deal_err=0. resetb low during WAIT → FSM returns to IDLE with deal_ack=0.
